// File: rtl/bcd_count_ctrl_pkg.sv
// Shared types and helpers for the BCD count controller.
package bcd_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Non-BCD nibbles saturate to 9 so a digit register never holds A..F.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

endpackage

// File: rtl/bcd_count_ctrl_if.sv
// Control/status bundle between host logic and the BCD count controller.
interface bcd_count_ctrl_if #(
    parameter int NUM_DIGITS = 2
) ();
    logic                    start;
    logic                    stop;
    logic                    clear;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_val;
    logic [4*NUM_DIGITS-1:0] limit;
    logic [4*NUM_DIGITS-1:0] count;
    logic                    running;
    logic                    done;
    logic                    tick;
    logic                    carry;

    modport master (
        output start, stop, clear, load, load_val, limit,
        input  count, running, done, tick, carry
    );

    modport slave (
        input  start, stop, clear, load, load_val, limit,
        output count, running, done, tick, carry
    );
endinterface

// File: rtl/bcd_digit.sv
// One BCD digit register; carry_out feeds the next digit's inc_in.
module bcd_digit
    import bcd_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_in,
    input  logic       clr,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output logic [3:0] digit,
    output logic       carry_out
);
    logic [3:0] r_digit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= 4'd0;
        end else if (clr) begin
            r_digit <= 4'd0;
        end else if (ld) begin
            r_digit <= bcd_clamp(ld_val);
        end else if (inc_in) begin
            r_digit <= (r_digit == BCD_MAX) ? 4'd0 : r_digit + 4'd1;
        end
    end

    assign digit     = r_digit;
    assign carry_out = inc_in && (r_digit == BCD_MAX);
endmodule

// File: rtl/bcd_count_ctrl.sv
// Run-control FSM, prescaler and terminal-count compare around a BCD digit chain.
//  state    | meaning
//  ST_IDLE  | stopped, count held, load allowed
//  ST_RUN   | prescaler running, ticks increment count
//  ST_PAUSE | stopped mid-run, prescaler frozen
//  ST_DONE  | terminal count reached, count held at limit
module bcd_count_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int PRESCALE   = 4
) (
    input logic              clk,
    input logic              rst_n,
    bcd_count_ctrl_if.slave  ctrl_if
);
    localparam int CW = 4 * NUM_DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_pre, w_pre_nxt;
    logic            r_running, r_done, r_tick, r_carry;
    logic            w_tick_ev, w_term, w_clr_cnt, w_ld_cnt;
    logic [NUM_DIGITS:0] w_chain;
    logic [CW-1:0]   w_count, w_inc_val;

    assign w_tick_ev  = (r_state == ST_RUN) && (r_pre == PRE_LAST) && !ctrl_if.clear;
    assign w_chain[0] = w_tick_ev;

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .clk       (clk),
                .rst_n     (rst_n),
                .inc_in    (w_chain[g]),
                .clr       (w_clr_cnt),
                .ld        (w_ld_cnt),
                .ld_val    (ctrl_if.load_val[4*g +: 4]),
                .digit     (w_count[4*g +: 4]),
                .carry_out (w_chain[g+1])
            );
            // Value the chain will hold after this edge, used for the limit match.
            assign w_inc_val[4*g +: 4] = !w_chain[g] ? w_count[4*g +: 4] :
                                         (w_count[4*g +: 4] == BCD_MAX) ? 4'd0 :
                                         w_count[4*g +: 4] + 4'd1;
        end
    endgenerate

    assign w_term = w_tick_ev && (ctrl_if.limit != '0) && (w_inc_val == ctrl_if.limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pre     <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_tick    <= 1'b0;
            r_carry   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pre     <= w_pre_nxt;
            r_running <= (w_state_nxt == ST_RUN);
            r_done    <= (w_state_nxt == ST_DONE);
            r_tick    <= w_tick_ev;
            r_carry   <= w_chain[NUM_DIGITS];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre;
        w_clr_cnt   = 1'b0;
        w_ld_cnt    = 1'b0;
        if (ctrl_if.clear) begin
            w_state_nxt = ST_IDLE;
            w_pre_nxt   = '0;
            w_clr_cnt   = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ctrl_if.load) begin
                        w_ld_cnt = 1'b1;
                    end else if (ctrl_if.start && !ctrl_if.stop) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    w_pre_nxt = (r_pre == PRE_LAST) ? '0 : r_pre + PW'(1);
                    if (w_term) begin
                        w_state_nxt = ST_DONE;
                    end else if (ctrl_if.stop) begin
                        w_state_nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (ctrl_if.load) begin
                        w_ld_cnt    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (ctrl_if.start && !ctrl_if.stop) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (ctrl_if.load) begin
                        w_ld_cnt    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (ctrl_if.start && !ctrl_if.stop) begin
                        w_clr_cnt   = 1'b1;
                        w_pre_nxt   = '0;
                        w_state_nxt = ST_RUN;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign ctrl_if.count   = w_count;
    assign ctrl_if.running = r_running;
    assign ctrl_if.done    = r_done;
    assign ctrl_if.tick    = r_tick;
    assign ctrl_if.carry   = r_carry;
endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench for bcd_count_ctrl: PRESCALE=4 main instance plus a PRESCALE=1 instance.
module tb_bcd_count_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_count_ctrl_if #(.NUM_DIGITS(2)) b1 ();
    bcd_count_ctrl_if #(.NUM_DIGITS(2)) b2 ();

    bcd_count_ctrl #(.NUM_DIGITS(2), .PRESCALE(4)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctrl_if (b1)
    );

    bcd_count_ctrl #(.NUM_DIGITS(2), .PRESCALE(1)) u_dut_p1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctrl_if (b2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bcd8(input int k);
        logic [3:0] hi, lo;
        hi = 4'((k / 10) % 10);
        lo = 4'(k % 10);
        return {hi, lo};
    endfunction

    task automatic pulse_start();
        b1.start = 1'b1; step(1); b1.start = 1'b0;
    endtask

    task automatic pulse_clear();
        b1.clear = 1'b1; step(1); b1.clear = 1'b0;
    endtask

    task automatic pulse_load(input logic [7:0] v);
        b1.load_val = v; b1.load = 1'b1; step(1); b1.load = 1'b0;
    endtask

    initial begin
        {b1.start, b1.stop, b1.clear, b1.load} = 4'b0;
        {b2.start, b2.stop, b2.clear, b2.load} = 4'b0;
        b1.load_val = 8'h00; b1.limit = 8'h00;
        b2.load_val = 8'h00; b2.limit = 8'h00;

        step(2);
        check("rst_count",   32'(b1.count),   32'h00);
        check("rst_running", 32'(b1.running), 32'd0);
        check("rst_done",    32'(b1.done),    32'd0);
        check("rst_tick",    32'(b1.tick),    32'd0);
        check("rst_carry",   32'(b1.carry),   32'd0);
        rst_n = 1'b1;
        step(1);

        // free-run 00..99 -> 00
        pulse_start();
        check("t1_running", 32'(b1.running), 32'd1);
        check("t1_count0",  32'(b1.count),   32'h00);
        for (int k = 1; k <= 100; k++) begin
            step(3);
            check("t1_notick", 32'(b1.tick), 32'd0);
            step(1);
            check("t1_count", 32'(b1.count), 32'(bcd8(k % 100)));
            check("t1_tick",  32'(b1.tick),  32'd1);
            check("t1_carry", 32'(b1.carry), (k == 100) ? 32'd1 : 32'd0);
        end
        pulse_clear();

        // terminal count
        b1.limit = 8'h12;
        pulse_start();
        step(47);
        check("t2_pre_count", 32'(b1.count), 32'h11);
        check("t2_pre_done",  32'(b1.done),  32'd0);
        step(1);
        check("t2_count",   32'(b1.count),   32'h12);
        check("t2_done",    32'(b1.done),    32'd1);
        check("t2_running", 32'(b1.running), 32'd0);
        step(8);
        check("t2_hold",   32'(b1.count), 32'h12);
        check("t2_notick", 32'(b1.tick),  32'd0);
        pulse_start();
        check("t2_restart_count", 32'(b1.count),   32'h00);
        check("t2_restart_run",   32'(b1.running), 32'd1);
        check("t2_restart_done",  32'(b1.done),    32'd0);
        b1.limit = 8'h00;
        pulse_clear();

        // pause keeps prescaler phase
        pulse_start();
        step(5);
        b1.stop = 1'b1; step(1); b1.stop = 1'b0;
        check("t3_paused", 32'(b1.running), 32'd0);
        check("t3_count",  32'(b1.count),   32'h01);
        step(10);
        check("t3_frozen", 32'(b1.count), 32'h01);
        pulse_start();
        check("t3_resume", 32'(b1.running), 32'd1);
        step(1);
        check("t3_early_tick",  32'(b1.tick),  32'd0);
        check("t3_early_count", 32'(b1.count), 32'h01);
        step(1);
        check("t3_tick",  32'(b1.tick),  32'd1);
        check("t3_count2", 32'(b1.count), 32'h02);
        pulse_clear();

        // load clamp, load ignored in RUN, clear in RUN
        pulse_load(8'h3C);
        check("t4_clamp", 32'(b1.count), 32'h39);
        pulse_start();
        pulse_load(8'h05);
        check("t4_ld_in_run", 32'(b1.count),   32'h39);
        check("t4_still_run", 32'(b1.running), 32'd1);
        pulse_clear();
        check("t4_clr_count", 32'(b1.count),   32'h00);
        check("t4_clr_idle",  32'(b1.running), 32'd0);

        // start&stop, clear&load, stop on terminal tick, load in DONE
        pulse_load(8'h55);
        check("t5_load", 32'(b1.count), 32'h55);
        b1.load_val = 8'h77; b1.clear = 1'b1; b1.load = 1'b1;
        step(1);
        b1.clear = 1'b0; b1.load = 1'b0;
        check("t5_clr_over_ld", 32'(b1.count), 32'h00);
        pulse_start();
        step(2);
        b1.start = 1'b1; b1.stop = 1'b1; step(1);
        check("t5_ss_pause", 32'(b1.running), 32'd0);
        step(1);
        check("t5_ss_in_pause", 32'(b1.running), 32'd0);
        b1.start = 1'b0; b1.stop = 1'b0;
        pulse_clear();
        pulse_load(8'h55);
        b1.limit = 8'h56;
        pulse_start();
        step(3);
        b1.stop = 1'b1; step(1); b1.stop = 1'b0;
        check("t5_stopterm_count", 32'(b1.count),   32'h56);
        check("t5_stopterm_done",  32'(b1.done),    32'd1);
        check("t5_stopterm_run",   32'(b1.running), 32'd0);
        pulse_load(8'h21);
        check("t5_ld_done_count", 32'(b1.count), 32'h21);
        check("t5_ld_done_idle",  32'(b1.done),  32'd0);
        b1.limit = 8'h00;
        pulse_clear();

        // PRESCALE=1 instance ticks every RUN cycle
        b2.start = 1'b1; step(1); b2.start = 1'b0;
        check("t5p1_run", 32'(b2.running), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            step(1);
            check("t5p1_count", 32'(b2.count), 32'(bcd8(k)));
            check("t5p1_tick",  32'(b2.tick),  32'd1);
        end

        // async reset mid-count
        pulse_start();
        step(188);
        check("t6_pre_count", 32'(b1.count), 32'h47);
        #1 rst_n = 1'b0;
        #1;
        check("t6_count",   32'(b1.count),   32'h00);
        check("t6_running", 32'(b1.running), 32'd0);
        check("t6_tick",    32'(b1.tick),    32'd0);
        check("t6_carry",   32'(b1.carry),   32'd0);
        check("t6_done",    32'(b1.done),    32'd0);
        #1 rst_n = 1'b1;
        step(2);
        check("t6_post_count", 32'(b1.count),   32'h00);
        check("t6_post_idle",  32'(b1.running), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
